// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard direction queue: direction encodings,
// scan-code constants and the opposite-direction helper.
package kbd_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  // {extended, scan code}
  localparam logic [8:0] KEY_ARROW_RIGHT = 9'h174;
  localparam logic [8:0] KEY_ARROW_LEFT  = 9'h16B;
  localparam logic [8:0] KEY_ARROW_UP    = 9'h175;
  localparam logic [8:0] KEY_ARROW_DOWN  = 9'h172;
  localparam logic [8:0] KEY_W           = 9'h01D;
  localparam logic [8:0] KEY_A           = 9'h01C;
  localparam logic [8:0] KEY_S           = 9'h01B;
  localparam logic [8:0] KEY_D           = 9'h023;
  localparam logic [8:0] KEY_SPACE       = 9'h029;

  // Opposite pairs differ only in bit 0 with this encoding.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Small synchronous FIFO of 2-bit direction commands; exposes the newest
// entry (tail) so the caller can filter against the last queued command.
module dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [1:0]                 din,
  output logic [1:0]                 head,
  output logic [1:0]                 tail,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign tail    = mem[wr_ptr - PTR_W'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_dir_queue.sv
// Direction controller: decodes key makes, rejects reversals/duplicates,
// buffers commands and applies one per game tick, with a pause toggle.
module kbd_dir_queue
  import kbd_pkg::*;
#(
  parameter int         DEPTH       = 4,
  parameter bit         ENABLE_WASD = 1'b1,
  parameter logic [1:0] INIT_DIR    = 2'b00,
  parameter logic [8:0] PAUSE_CODE  = 9'h029
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       key_valid,
  input  logic [8:0]                 key_code,
  input  logic                       key_make,
  input  logic                       tick,
  output logic [1:0]                 dir,
  output logic                       dir_update,
  output logic                       paused,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic                       drop
);

  dir_t       key_dir;
  logic       key_hit;
  logic       pause_hit;
  logic [1:0] ref_dir;
  logic       acceptable;
  logic       push;
  logic       pop;
  logic [1:0] head;
  logic [1:0] tail;
  logic       full;
  logic       empty;

  always_comb begin
    key_dir = DIR_RIGHT;
    key_hit = 1'b0;
    if (key_valid && key_make) begin
      key_hit = 1'b1;
      if      (key_code == KEY_ARROW_RIGHT)            key_dir = DIR_RIGHT;
      else if (key_code == KEY_ARROW_LEFT)             key_dir = DIR_LEFT;
      else if (key_code == KEY_ARROW_UP)               key_dir = DIR_UP;
      else if (key_code == KEY_ARROW_DOWN)             key_dir = DIR_DOWN;
      else if (ENABLE_WASD && key_code == KEY_D)       key_dir = DIR_RIGHT;
      else if (ENABLE_WASD && key_code == KEY_A)       key_dir = DIR_LEFT;
      else if (ENABLE_WASD && key_code == KEY_W)       key_dir = DIR_UP;
      else if (ENABLE_WASD && key_code == KEY_S)       key_dir = DIR_DOWN;
      else                                             key_hit = 1'b0;
    end
  end

  // Filter against the newest queued command, or the live direction if none.
  assign pause_hit  = key_valid && key_make && (key_code == PAUSE_CODE);
  assign ref_dir    = empty ? dir : tail;
  assign acceptable = key_hit && !paused && (key_dir != ref_dir) &&
                      (key_dir != opposite(ref_dir));
  assign pop        = tick && !paused && !empty;
  assign push       = acceptable;

  dir_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (key_dir),
    .head  (head),
    .tail  (tail),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir        <= INIT_DIR;
      dir_update <= 1'b0;
      paused     <= 1'b0;
      drop       <= 1'b0;
    end else begin
      dir_update <= pop;
      drop       <= acceptable && full && !pop;
      if (pop)       dir    <= head;
      if (pause_hit) paused <= !paused;
    end
  end

endmodule

// File: doc/kbd_dir_queue.md
Name: kbd_dir_queue

Overview:
Parametrised direction controller for the game core. It consumes decoded PS/2 key events (one-cycle valid, 9-bit code with extended bit, make/break flag) and filters them for reversal and duplicates. Accepted commands are buffered in a small FIFO, and one command is applied per game tick. A pause toggle is also provided. The block sits between the keyboard decoder and the game-state logic, replacing the combinational key-to-direction mapping.

Parameters:
DEPTH, 4, FIFO entries of buffered direction commands (power of two, 2..16)
ENABLE_WASD, 1, when 1, W/A/S/D (8'h1D/8'h1C/8'h1B/8'h23, non-extended) also map to up/left/down/right
INIT_DIR, 2'b00, direction loaded at reset (00 right)
PAUSE_CODE, 9'h029, key code that toggles pause (space)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle strobe: key_code/key_make valid
key_code  in  9  {extended, scan code}
key_make  in  1  1 = press, 0 = release
tick  in  1  one-cycle game-step strobe
dir  out  2  current direction: 00 right, 01 left, 10 up, 11 down
dir_update  out  1  one-cycle pulse when dir was loaded from the queue
paused  out  1  pause state
q_count  out  $clog2(DEPTH+1)  queued command count
drop  out  1  one-cycle pulse: command rejected because the queue was full

Behaviour:
- Reset (async assert, sync release) values: dir=INIT_DIR, dir_update=0, paused=0, q_count=0, drop=0, FIFO pointers=0.
- Key map, applied only when key_valid=1 and key_make=1:
  - Extended codes: 9'h174 right, 9'h16B left, 9'h175 up, 9'h172 down.
  - WASD codes per ENABLE_WASD.
  - All other codes and all break events are ignored, including the non-extended 8'h74 etc.
- Pause: a PAUSE_CODE make toggles paused, registered in the next cycle. The queue is retained across pause.
- Reference direction: REF = tail entry (newest queued) if q_count>0, else dir.
- Accept rule: a mapped direction D is enqueued iff paused=0, D≠REF, and D≠opposite(REF). Opposite pairs: right/left, up/down.
  - Rejected for reversal or duplicate: silently discarded, no drop pulse.
- Full: an acceptable D with q_count==DEPTH and no pop in the same cycle is discarded, and drop pulses in the next cycle.
- Pop: on tick=1 with paused=0 and q_count>0, the head is loaded into dir, registered, and dir_update=1 in the next cycle. tick with an empty queue or while paused leaves dir unchanged and no pulse.
- Simultaneous push and pop in the same cycle: both happen, q_count unchanged, a full queue accepts, no drop. REF is evaluated on pre-pop state.
- Latency: key_valid at cycle N → q_count visible at N+1. tick at N → dir/dir_update at N+1.
- Pointers wrap modulo DEPTH; q_count never exceeds DEPTH or underflows.
- Reset mid-operation: queue flushed, dir=INIT_DIR, paused cleared immediately on rst_n low.

Decomposition:
- Shared package kbd_pkg:
  - direction encodings DIR_RIGHT/LEFT/UP/DOWN
  - opposite-direction function
  - scan-code constants (arrows extended, WASD, space)
- One sub-module: dir_fifo, a synchronous FIFO of 2-bit entries, parameter DEPTH. It provides push/pop/full/empty/count/tail outputs and exposes the tail for REF.
- Top holds the decode, filter, pause and dir register.

Test Plan:
1. Reset with INIT_DIR=00 → dir=00, q_count=0, paused=0. Make 9'h175 (up) then tick → q_count=1 after 1 cycle; dir=10 with dir_update pulse 1 cycle after tick.
2. dir=00 right, empty queue; make 9'h16B (left) and 9'h174 (right) → both rejected, q_count stays 0, no drop. Make 9'h172 (down) → accepted.
3. DEPTH=4: enqueue up, left, down, right alternately (each legal vs tail), then a fifth legal key → drop pulses once, q_count=4. Four ticks → dir sequence 10, 01, 11, 00, then q_count=0.
4. Queue full; a legal key and tick in the same cycle → no drop, q_count stays 4, dir=head.
5. Make 9'h029 → paused=1. Make up, tick → q_count and dir unchanged. Second 9'h029 then tick → pops retained entries normally. Break events of all keys have no effect.
6. ENABLE_WASD=1: make 9'h01D → up accepted. ENABLE_WASD=0 → ignored. Non-extended 9'h074 → ignored. Assert rst_n low mid-queue → q_count=0, dir=INIT_DIR immediately.
